// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, redirect input and the decode-side handshake.
// The master modport is the fetch unit; slave is the surrounding core/ROM/decode.
interface instr_fetch_unit_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  modport master (
    output rom_addr,
    input  rom_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fetch_fault
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fetch_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: drives the ROM address, queues {pc, instr} in a prefetch FIFO for decode.
// Define IFU_FAULT_CHECK_EN to enable range/misalignment checks with a sticky fault and HALT.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FIFO_DEPTH    = 2,
  parameter int          ROM_WORD_SIZE = 256
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus_io
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthC   = CW'(FIFO_DEPTH);
  localparam logic [29:0]   RomWords = 30'(ROM_WORD_SIZE);
`ifdef IFU_FAULT_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  typedef enum logic {RUN, HALT} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetchPc_q, fetchPc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic            fault_q, fault_d;
  logic [31:0]     memPc    [FIFO_DEPTH];
  logic [31:0]     memInstr [FIFO_DEPTH];
  logic            outValid, pop, push, flush, rangeFault, misalign;

  assign outValid   = (count_q != '0);
  assign pop        = outValid & bus_io.out_ready;
  assign rangeFault = CheckEn && (fetchPc_q[31:2] >= RomWords);
  assign misalign   = CheckEn && (bus_io.redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fault_d   = fault_q;
    push      = 1'b0;
    flush     = 1'b0;
    case (state_q)
      RUN: begin
        if (bus_io.redirect_valid) begin
          flush     = 1'b1;
          fetchPc_d = bus_io.redirect_pc;
          if (misalign) begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        end else if (rangeFault) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          push = (count_q < DepthC) || pop;
        end
      end
      default: ;
    endcase
    // A redirect discards any same-cycle pop; otherwise push/pop update independently.
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) begin
        tail_d    = tail_q + PW'(1);
        fetchPc_d = fetchPc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      fetchPc_q <= RESET_PC;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fault_q   <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memPc[tail_q]    <= fetchPc_q;
      memInstr[tail_q] <= bus_io.rom_instr;
    end
  end

  assign bus_io.rom_addr    = fetchPc_q;
  assign bus_io.out_valid   = outValid;
  assign bus_io.out_pc      = outValid ? memPc[head_q] : '0;
  assign bus_io.out_instr   = outValid ? memInstr[head_q] : '0;
  assign bus_io.fetch_fault = CheckEn & fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected {pc, instr} per scenario.
// A second instance with a 4-word ROM exercises the range boundary.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t expQ[$];

  instr_fetch_unit_if bus();
  instr_fetch_unit_if busSmall();

  function automatic logic [31:0] romWord(input logic [31:0] a);
    logic [31:0] w;
    case (a[31:2])
      30'd0:   w = 32'h0050_0293;
      30'd1:   w = 32'h00A0_0313;
      30'd2:   w = 32'h0000_0013;
      30'd3:   w = 32'h0000_0013;
      default: w = 32'hCAFE_0000 ^ a;
    endcase
    return w;
  endfunction

  assign bus.rom_instr      = romWord(bus.rom_addr);
  assign busSmall.rom_instr = romWord(busSmall.rom_addr);

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .ROM_WORD_SIZE(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_io(bus)
  );

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .ROM_WORD_SIZE(4)
  ) dutSmall (
    .clk(clk), .rst_n(rst_n), .bus_io(busSmall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input logic [31:0] pc);
    expQ.push_back('{pc: pc, instr: romWord(pc)});
  endtask

  // Pops one scoreboard entry and compares the main DUT head against it.
  task automatic test_head_main(input string tag);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_queue: got empty scoreboard expected entry", tag);
      return;
    end
    e = expQ.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_valid: got %b expected 1", tag, bus.out_valid);
    end
    checks++;
    if (bus.out_pc !== e.pc) begin
      errors++;
      $display("[TB] FAIL %s_pc: got %h expected %h", tag, bus.out_pc, e.pc);
    end
    checks++;
    if (bus.out_instr !== e.instr) begin
      errors++;
      $display("[TB] FAIL %s_instr: got %h expected %h", tag, bus.out_instr, e.instr);
    end
  endtask

  task automatic applyReset(input logic ready);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = ready;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n                   = 1'b0;
    bus.out_ready           = 1'b1;
    bus.redirect_valid      = 1'b0;
    bus.redirect_pc         = 32'h0;
    busSmall.out_ready      = 1'b0;
    busSmall.redirect_valid = 1'b0;
    busSmall.redirect_pc    = 32'h0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc: got %h expected 0", bus.out_pc);
    end
    checks++;
    if (bus.out_instr !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_instr: got %h expected 0", bus.out_instr);
    end
    checks++;
    if (bus.rom_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_rom_addr: got %h expected 0", bus.rom_addr);
    end
    checks++;
    if (bus.fetch_fault !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_fault: got %b expected 0", bus.fetch_fault);
    end
  endtask

  task automatic test_sequential;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) pushExp(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      test_head_main("seq");
    end
  endtask

  task automatic test_backpressure;
    applyReset(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_pc !== 32'h0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold: got valid=%b pc=%h expected valid=1 pc=0", bus.out_valid, bus.out_pc);
      end
    end
    checks++;
    if (dut.count_q !== 2'd2) begin
      errors++; $display("[TB] FAIL bp_count: got %0d expected 2", dut.count_q);
    end
    checks++;
    if (bus.rom_addr !== 32'h8) begin
      errors++; $display("[TB] FAIL bp_rom_addr: got %h expected 8", bus.rom_addr);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) pushExp(32'(i * 4));
    for (int i = 0; i < 3; i++) begin
      test_head_main("bp_drain");
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL redir_flush: got valid=%b pc=%h instr=%h expected all 0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    checks++;
    if (bus.rom_addr !== 32'h40) begin
      errors++; $display("[TB] FAIL redir_rom_addr: got %h expected 40", bus.rom_addr);
    end
    pushExp(32'h40);
    pushExp(32'h44);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      test_head_main("redir");
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_rst_out: got valid=%b pc=%h instr=%h expected all 0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    checks++;
    if (bus.rom_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL async_rst_rom_addr: got %h expected 0", bus.rom_addr);
    end
  endtask

  task automatic test_misalign;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h42) begin
      errors++;
      $display("[TB] FAIL misalign_flush: got valid=%b rom_addr=%h expected valid=0 rom_addr=42",
               bus.out_valid, bus.rom_addr);
    end
`ifdef IFU_FAULT_CHECK_EN
    checks++;
    if (bus.fetch_fault !== 1'b1) begin
      errors++; $display("[TB] FAIL misalign_fault: got %b expected 1", bus.fetch_fault);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.rom_addr !== 32'h42 || bus.out_valid !== 1'b0 || bus.fetch_fault !== 1'b1) begin
      errors++;
      $display("[TB] FAIL halt_ignore: got rom_addr=%h valid=%b fault=%b expected 42/0/1",
               bus.rom_addr, bus.out_valid, bus.fetch_fault);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.fetch_fault !== 1'b0) begin
      errors++; $display("[TB] FAIL fault_clear: got %b expected 0", bus.fetch_fault);
    end
`else
    checks++;
    if (bus.fetch_fault !== 1'b0) begin
      errors++; $display("[TB] FAIL misalign_nofault: got %b expected 0", bus.fetch_fault);
    end
    pushExp(32'h42);
    @(posedge clk); #1;
    test_head_main("misalign_verbatim");
    rst_n = 1'b0;
`endif
  endtask

  task automatic test_range;
    busSmall.out_ready = 1'b1;
    rst_n              = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) pushExp(32'(i * 4));
`ifndef IFU_FAULT_CHECK_EN
    pushExp(32'h10);
`endif
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      @(posedge clk); #1;
      e = expQ.pop_front();
      checks++;
      if (busSmall.out_valid !== 1'b1 || busSmall.out_pc !== e.pc || busSmall.out_instr !== e.instr) begin
        errors++;
        $display("[TB] FAIL range_seq: got valid=%b pc=%h instr=%h expected 1/%h/%h",
                 busSmall.out_valid, busSmall.out_pc, busSmall.out_instr, e.pc, e.instr);
      end
    end
    @(posedge clk); #1;
`ifdef IFU_FAULT_CHECK_EN
    checks++;
    if (busSmall.fetch_fault !== 1'b1 || busSmall.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_fault: got fault=%b valid=%b expected fault=1 valid=0",
               busSmall.fetch_fault, busSmall.out_valid);
    end
`else
    begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      if (busSmall.out_valid !== 1'b1 || busSmall.out_pc !== e.pc || busSmall.out_instr !== e.instr
          || busSmall.fetch_fault !== 1'b0) begin
        errors++;
        $display("[TB] FAIL range_alias: got valid=%b pc=%h instr=%h fault=%b expected 1/%h/%h/0",
                 busSmall.out_valid, busSmall.out_pc, busSmall.out_instr, busSmall.fetch_fault,
                 e.pc, e.instr);
      end
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_async_reset();
    test_misalign();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RV32I core, sitting between the PC/redirect logic and the decode stage, directly in front of the instruction ROM. Drives the ROM's byte address, captures the combinational instruction word with its PC into a small prefetch FIFO, and presents it to decode over a valid/ready handshake. Taken branches and jumps arrive as a redirect that flushes the FIFO and restarts fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset; word-aligned.
- `FIFO_DEPTH`, default 2: prefetch entries; power of two, 2..8.
- `ROM_WORD_SIZE`, default 256: ROM depth in words, used for range checking.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  32  byte address to ROM; equals fetch PC.
- `rom_instr`  in  32  instruction word from ROM, combinational from `rom_addr`.
- `redirect_valid`  in  1  taken branch/jump this cycle.
- `redirect_pc`  in  32  redirect target byte address.
- `out_valid`  out  1  FIFO head valid to decode.
- `out_ready`  in  1  decode accepts head.
- `out_instr`  out  32  head instruction; 0 when `out_valid`=0.
- `out_pc`  out  32  head PC; 0 when `out_valid`=0.
- `fetch_fault`  out  1  sticky fault flag.

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- pop = `out_valid` & `out_ready`.
- push = RUN & !`redirect_valid` & !range_fault & (count < FIFO_DEPTH | pop). A push writes {`rom_addr`, `rom_instr`} at the tail and sets fetch_pc <= fetch_pc + 4, with 32-bit wrap.
- Simultaneous push and pop: count unchanged, head advances.
- Redirect in RUN has priority over push and pop. It sets count <= 0, resets the pointers, sets fetch_pc <= `redirect_pc`, and pushes nothing that cycle. A pop in the same cycle is discarded and has no effect.
- range_fault = fetch_pc[31:2] >= ROM_WORD_SIZE. In RUN, a range fault with no redirect gives: HALT, `fetch_fault` <= 1, no push.
- Misaligned redirect (`redirect_pc[1:0]` != 0) in RUN gives: HALT, `fetch_fault` <= 1, FIFO flushed, fetch_pc <= `redirect_pc`.
- In HALT:
  - No pushes.
  - Entries already queued still drain normally.
  - `redirect_valid` is ignored.
  - Only reset exits HALT.
- `out_valid` = (count != 0).
- Width rules:
  - count is $clog2(FIFO_DEPTH)+1 bits.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, so `rom_addr` = RESET_PC.
  - count = 0, pointers = 0.
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `fetch_fault` = 0.
  - State = RUN.
- Latency:
  - First instruction: `out_valid`=1 after the first rising edge following reset deassertion.
  - Redirect asserted before edge N: `out_valid`=0 after edge N. The target instruction is valid after edge N+1.
- Throughput: one instruction per cycle when `out_ready` is held high.
- Stability: while `out_valid` & !`out_ready`, `out_instr`/`out_pc` stay constant unless a redirect flushes.
- Reset asserted mid-operation clears all state immediately (asynchronous), including a sticky fault.
- Full FIFO with `out_ready`=0: fetch_pc holds and `rom_addr` is stable.

## Configuration
- Macro: `IFU_FAULT_CHECK_EN`.
- Defined: range and misalignment checks active; HALT and `fetch_fault` behave as above.
- Undefined:
  - No checks, and HALT is unreachable.
  - `fetch_fault` is tied to 0.
  - Redirect always accepted with `redirect_pc` used verbatim.
  - Out-of-range addresses are pushed as fetched (the ROM aliases them).

## Test plan
- Reset with RESET_PC=0, ROM words 0..3 = 0x00500293, 0x00A00313, 0x00000013, 0x00000013; `out_ready`=1. Required: `out_pc` sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, with matching `out_instr`.
- Backpressure with `out_ready`=0 for 5 cycles, DEPTH=2. Required:
  - count reaches 2 and `rom_addr` holds at 0x8.
  - `out_pc`=0x0 stays stable.
  - After `out_ready` is raised, `out_pc` goes 0x0, 0x4, 0x8 with no gap.
- `redirect_valid`=1, `redirect_pc`=0x40 while the FIFO holds 2 entries and `out_ready`=1. Required: `out_valid`=0 the next cycle, then `out_pc`=0x40.
- `IFU_FAULT_CHECK_EN` defined, `redirect_pc`=0x42. Required: `fetch_fault`=1 and `out_valid`=0 next cycle; a later redirect to 0x10 is ignored; `rst_n` low clears the fault.
- `IFU_FAULT_CHECK_EN` defined, ROM_WORD_SIZE=4, sequential fetch. Required: PCs 0x0..0xC delivered, then `fetch_fault`=1 with no entry at 0x10. Without the macro, 0x10 is delivered with `fetch_fault`=0.
- Assert `rst_n` low asynchronously mid-stream (between edges). Required: `out_valid`, `out_instr`, `out_pc` go to 0 and `rom_addr` goes to RESET_PC immediately.
